// File: rtl/mat_weight_loader.sv
// Loads a WIDTH x WIDTH weight tile from data memory into the matrix unit, one row per cycle.
// Rows travel as packed IEEE-754 single-precision bit patterns; all-zero bits encode 0.0.
module mat_weight_loader #(
  parameter int WIDTH              = 16,
  parameter int DATA_MEM_ADDR_SIZE = 32,
  parameter int MEM_LATENCY        = 0,
  parameter int WIDTH_ADDR_SIZE    = $clog2(WIDTH)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DATA_MEM_ADDR_SIZE-1:0]    base_addr,
  input  logic [WIDTH_ADDR_SIZE:0]         num_rows,
  input  logic                             reverse,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_MEM_ADDR_SIZE-1:0]    data_mem_read_addr,
  input  logic [WIDTH-1:0][31:0]           data_mem_data_out,
  output logic                             unit_set_weight,
  output logic [WIDTH_ADDR_SIZE-1:0]       unit_set_weight_row,
  output logic [WIDTH-1:0][31:0]           unit_data_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [WIDTH_ADDR_SIZE:0]         W_ROWS     = (WIDTH_ADDR_SIZE+1)'(WIDTH);
  localparam logic [WIDTH_ADDR_SIZE-1:0]       LAST_ROW   = WIDTH_ADDR_SIZE'(WIDTH-1);
  localparam logic [WIDTH_ADDR_SIZE-1:0]       IDX_ONE    = WIDTH_ADDR_SIZE'(1);
  localparam logic [DATA_MEM_ADDR_SIZE-1:0]    ADDR_ONE   = DATA_MEM_ADDR_SIZE'(1);
  localparam int                               DRAIN_LAST_I = (MEM_LATENCY > 0) ? MEM_LATENCY-1 : 0;
  localparam logic [1:0]                       DRAIN_LAST = 2'(DRAIN_LAST_I);

  state_t                      state;
  logic [WIDTH_ADDR_SIZE-1:0]  idx;
  logic [WIDTH_ADDR_SIZE:0]    nrows;
  logic                        rev_q;
  logic [1:0]                  drain_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      idx                <= '0;
      nrows              <= '0;
      rev_q              <= 1'b0;
      drain_cnt          <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      data_mem_read_addr <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done               <= 1'b0;
          busy               <= 1'b0;
          data_mem_read_addr <= '0;
          state              <= IDLE;
          if (start) begin
            state              <= ISSUE;
            busy               <= 1'b1;
            idx                <= '0;
            rev_q              <= reverse;
            nrows              <= (num_rows > W_ROWS) ? W_ROWS : num_rows;
            data_mem_read_addr <= base_addr;
          end
        end
        ISSUE: begin
          idx <= idx + IDX_ONE;
          if (idx == LAST_ROW) begin
            drain_cnt <= '0;
            if (MEM_LATENCY > 0) begin
              state <= DRAIN;
            end else begin
              state              <= DONE;
              busy               <= 1'b0;
              done               <= 1'b1;
              data_mem_read_addr <= '0;
            end
          end else begin
            data_mem_read_addr <= data_mem_read_addr + ADDR_ONE;
          end
        end
        DRAIN: begin
          // Address holds at the last row while in-flight reads return.
          if (drain_cnt == DRAIN_LAST) begin
            state              <= DONE;
            busy               <= 1'b0;
            done               <= 1'b1;
            data_mem_read_addr <= '0;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic                        issuing;
  logic [WIDTH_ADDR_SIZE-1:0]  issue_row;
  logic                        issue_zero;
  logic                        wr_valid;
  logic [WIDTH_ADDR_SIZE-1:0]  wr_row;
  logic                        wr_zero;

  assign issuing    = (state == ISSUE);
  assign issue_row  = rev_q ? (LAST_ROW - idx) : idx;
  assign issue_zero = ({1'b0, idx} >= nrows);

  generate
    if (MEM_LATENCY == 0) begin : g_no_pipe
      assign wr_valid = issuing;
      assign wr_row   = issue_row;
      assign wr_zero  = issue_zero;
    end else begin : g_pipe
      logic [MEM_LATENCY-1:0]                      pv;
      logic [MEM_LATENCY-1:0]                      pz;
      logic [MEM_LATENCY-1:0][WIDTH_ADDR_SIZE-1:0] pr;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          pv <= '0;
          pz <= '0;
          pr <= '0;
        end else begin
          pv[0] <= issuing;
          pz[0] <= issue_zero;
          pr[0] <= issue_row;
          for (int unsigned s = 1; s < MEM_LATENCY; s++) begin
            pv[s] <= pv[s-1];
            pz[s] <= pz[s-1];
            pr[s] <= pr[s-1];
          end
        end
      end

      assign wr_valid = pv[MEM_LATENCY-1];
      assign wr_row   = pr[MEM_LATENCY-1];
      assign wr_zero  = pz[MEM_LATENCY-1];
    end
  endgenerate

  // Memory data passes straight through to the unit in the cycle its tag emerges.
  always_comb begin
    unit_set_weight     = wr_valid;
    unit_set_weight_row = '0;
    unit_data_in        = '0;
    if (wr_valid) begin
      unit_set_weight_row = wr_row;
      if (!wr_zero) unit_data_in = data_mem_data_out;
    end
  end

endmodule

// File: tb/tb_mat_weight_loader.sv
// Directed bench: one WIDTH=4 loader with zero memory latency (u0) and one with latency 2 (u2).
module tb_mat_weight_loader;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start0 = 1'b0;
  logic              start2 = 1'b0;
  logic [31:0]       base = '0;
  logic [2:0]        nrows = 3'd4;
  logic              rev = 1'b0;

  logic              busy0, done0, sw0, busy2, done2, sw2;
  logic [31:0]       addr0, addr2;
  logic [1:0]        row0, row2;
  logic [3:0][31:0]  din0, din2, mem0, mem2;
  logic [31:0]       a1 = '0, a2 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0][31:0] memrow(input logic [31:0] a);
    logic [3:0][31:0] r;
    for (int j = 0; j < 4; j++) r[j] = {8'h40, a[15:0], 8'(j)};
    return r;
  endfunction

  assign mem0 = memrow(addr0);
  always @(posedge clk) begin
    a1 <= addr2;
    a2 <= a1;
  end
  assign mem2 = memrow(a2);

  mat_weight_loader #(.WIDTH(4), .DATA_MEM_ADDR_SIZE(32), .MEM_LATENCY(0)) u0 (
    .clock(clk), .reset(rst), .start(start0), .base_addr(base), .num_rows(nrows),
    .reverse(rev), .busy(busy0), .done(done0), .data_mem_read_addr(addr0),
    .data_mem_data_out(mem0), .unit_set_weight(sw0), .unit_set_weight_row(row0),
    .unit_data_in(din0));

  mat_weight_loader #(.WIDTH(4), .DATA_MEM_ADDR_SIZE(32), .MEM_LATENCY(2)) u2 (
    .clock(clk), .reset(rst), .start(start2), .base_addr(base), .num_rows(nrows),
    .reverse(rev), .busy(busy2), .done(done2), .data_mem_read_addr(addr2),
    .data_mem_data_out(mem2), .unit_set_weight(sw2), .unit_set_weight_row(row2),
    .unit_data_in(din2));

  // Leaves the bench at the negedge inside cycle 1 of a u0 load.
  task automatic kick0(input logic [31:0] b, input logic [2:0] n, input logic r);
    base = b; nrows = n; rev = r; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy0, done0, sw0, row0} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl0 got %b expected 00000", {busy0, done0, sw0, row0});
    end
    checks++;
    if (addr0 !== 32'h0 || din0 !== 128'h0) begin
      errors++; $display("FAIL reset_data0 got addr %h din %h expected zeros", addr0, din0);
    end
    checks++;
    if ({busy2, done2, sw2, row2} !== 5'b0 || addr2 !== 32'h0 || din2 !== 128'h0) begin
      errors++; $display("FAIL reset_u2 got ctl %b addr %h expected zeros", {busy2, done2, sw2, row2}, addr2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] ea; logic [4:0] ectl; logic [3:0][31:0] ed;
    kick0(32'd8, 3'd4, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      ea   = (k <= 4) ? 32'(8 + k - 1) : 32'h0;
      ectl = {k <= 4, k == 5, k <= 4, (k <= 4) ? 2'(k - 1) : 2'd0};
      ed   = (k <= 4) ? memrow(ea) : '0;
      checks++;
      if ({busy0, done0, sw0, row0} !== ectl) begin
        errors++; $display("FAIL basic_ctl cycle %0d got %b expected %b", k, {busy0, done0, sw0, row0}, ectl);
      end
      checks++;
      if (addr0 !== ea) begin
        errors++; $display("FAIL basic_addr cycle %0d got %h expected %h", k, addr0, ea);
      end
      checks++;
      if (din0 !== ed) begin
        errors++; $display("FAIL basic_data cycle %0d got %h expected %h", k, din0, ed);
      end
    end
  endtask

  task automatic test_reverse_latency;
    logic [31:0] ea; logic [4:0] ectl; logic [3:0][31:0] ed; logic w;
    base = 32'd0; nrows = 3'd4; rev = 1'b1; start2 = 1'b1;
    @(posedge clk); @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      w    = (k >= 3 && k <= 6);
      ea   = (k <= 4) ? 32'(k - 1) : ((k <= 6) ? 32'd3 : 32'd0);
      ectl = {k <= 6, k == 7, w, w ? 2'(6 - k) : 2'd0};
      ed   = w ? memrow(32'(k - 3)) : '0;
      checks++;
      if ({busy2, done2, sw2, row2} !== ectl) begin
        errors++; $display("FAIL rev_lat_ctl cycle %0d got %b expected %b", k, {busy2, done2, sw2, row2}, ectl);
      end
      checks++;
      if (addr2 !== ea) begin
        errors++; $display("FAIL rev_lat_addr cycle %0d got %h expected %h", k, addr2, ea);
      end
      checks++;
      if (din2 !== ed) begin
        errors++; $display("FAIL rev_lat_data cycle %0d got %h expected %h", k, din2, ed);
      end
    end
    rev = 1'b0;
  endtask

  task automatic test_partial;
    logic [2:0]  tn [3] = '{3'd2, 3'd0, 3'd7};
    logic [31:0] tb [3] = '{32'd20, 32'd24, 32'd28};
    logic [3:0]  tz [3] = '{4'b1100, 4'b1111, 4'b0000};
    logic [31:0] ea; logic [3:0][31:0] ed;
    for (int c = 0; c < 3; c++) begin
      kick0(tb[c], tn[c], 1'b0);
      for (int k = 1; k <= 5; k++) begin
        if (k > 1) @(negedge clk);
        if (k <= 4) begin
          ea = tb[c] + 32'(k - 1);
          ed = tz[c][k-1] ? '0 : memrow(ea);
          checks++;
          if (sw0 !== 1'b1 || row0 !== 2'(k - 1) || addr0 !== ea) begin
            errors++; $display("FAIL partial_wr n=%0d cycle %0d got sw %b row %0d addr %h expected 1 %0d %h",
                               tn[c], k, sw0, row0, addr0, k - 1, ea);
          end
          checks++;
          if (din0 !== ed) begin
            errors++; $display("FAIL partial_data n=%0d cycle %0d got %h expected %h", tn[c], k, din0, ed);
          end
        end else begin
          checks++;
          if (done0 !== 1'b1 || sw0 !== 1'b0) begin
            errors++; $display("FAIL partial_done n=%0d got done %b sw %b expected 1 0", tn[c], done0, sw0);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start;
    logic [31:0] ea;
    kick0(32'd60, 3'd4, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) begin start0 = 1'b1; base = 32'd200; end
      if (k == 3) start0 = 1'b0;
      ea = (k <= 4) ? 32'(60 + k - 1) : 32'h0;
      checks++;
      if (addr0 !== ea || done0 !== (k == 5) || busy0 !== (k <= 4)) begin
        errors++; $display("FAIL ignored_start cycle %0d got addr %h done %b busy %b expected %h %b %b",
                           k, addr0, done0, busy0, ea, k == 5, k <= 4);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ea;
    kick0(32'd40, 3'd4, 1'b0);
    for (int k = 2; k <= 5; k++) @(negedge clk);
    checks++;
    if (done0 !== 1'b1) begin
      errors++; $display("FAIL b2b_first_done got %b expected 1", done0);
    end
    base = 32'd100; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      ea = (k <= 4) ? 32'(100 + k - 1) : 32'h0;
      checks++;
      if (addr0 !== ea || busy0 !== (k <= 4) || done0 !== (k == 5)) begin
        errors++; $display("FAIL b2b_second cycle %0d got addr %h busy %b done %b expected %h %b %b",
                           k, addr0, busy0, done0, ea, k <= 4, k == 5);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [31:0] ea [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    kick0(32'hFFFF_FFFE, 3'd4, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (addr0 !== ea[k-1] || din0 !== memrow(ea[k-1])) begin
        errors++; $display("FAIL wrap cycle %0d got addr %h expected %h", k, addr0, ea[k-1]);
      end
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen_done;
    kick0(32'd0, 3'd4, 1'b0);
    @(negedge clk); @(negedge clk);
    checks++;
    if (sw0 !== 1'b1 || row0 !== 2'd2) begin
      errors++; $display("FAIL mid_pre_reset got sw %b row %0d expected 1 2", sw0, row0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy0, done0, sw0, row0} !== 5'b0 || addr0 !== 32'h0 || din0 !== 128'h0) begin
      errors++; $display("FAIL mid_reset got ctl %b addr %h expected zeros", {busy0, done0, sw0, row0}, addr0);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done0 === 1'b1 || sw0 === 1'b1 || busy0 === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL mid_no_activity got %0d active cycles expected 0", seen_done);
    end
    kick0(32'd4, 3'd4, 1'b0);
    checks++;
    if (addr0 !== 32'd4 || sw0 !== 1'b1 || row0 !== 2'd0 || din0 !== memrow(32'd4)) begin
      errors++; $display("FAIL mid_restart got addr %h sw %b row %0d expected 4 1 0", addr0, sw0, row0);
    end
    for (int k = 2; k <= 5; k++) @(negedge clk);
    checks++;
    if (done0 !== 1'b1) begin
      errors++; $display("FAIL mid_restart_done got %b expected 1", done0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_reverse_latency;
    test_partial;
    test_ignored_start;
    test_back_to_back;
    test_wrap;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_weight_loader.md
# mat_weight_loader

Sequencer that loads a full WIDTH×WIDTH weight tile into the matrix unit from data memory, one row per cycle, on a start/done handshake. Sits between the matrix control and the matrix unit/data memory; the control issues a single start with a base address instead of stepping set_weight rows itself. Supports reversed row order, partial tiles with zero fill, and a configurable data-memory read latency.

## Interface
- WIDTH, 16, systolic array dimension (rows/cols per tile)
- DATA_MEM_ADDR_SIZE, 32, data memory address width
- MEM_LATENCY, 0, cycles from address presented to row valid on data_mem_data_out (0..3)
- WIDTH_ADDR_SIZE, $clog2(WIDTH), derived row index width

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request a tile load; sampled when idle or done
- base_addr  in  DATA_MEM_ADDR_SIZE  address of first weight row
- num_rows  in  WIDTH_ADDR_SIZE+1  rows taken from memory; remaining rows zero-filled
- reverse  in  1  1: memory row i goes to unit row WIDTH-1-i
- busy  out  1  high while a load is in progress
- done  out  1  one-cycle pulse after final row written
- data_mem_read_addr  out  DATA_MEM_ADDR_SIZE  row address to data memory
- data_mem_data_out  in  shortreal[WIDTH]  row returned by data memory
- unit_set_weight  out  1  write enable to matrix unit weight row
- unit_set_weight_row  out  WIDTH_ADDR_SIZE  target weight row
- unit_data_in  out  shortreal[WIDTH]  weight row data

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE + start: latch base_addr, reverse, and nrows = min(num_rows, WIDTH); clear issue counter i; go ISSUE. Inputs ignored after capture.
- Start while ISSUE/DRAIN: ignored, no effect.
- ISSUE: drive data_mem_read_addr = base + i (mod 2^DATA_MEM_ADDR_SIZE); push {row, zero=(i>=nrows)} into a MEM_LATENCY-deep tag pipeline; i++. At i = WIDTH-1: go DRAIN if MEM_LATENCY>0, else DONE.
- Row mapping: row = reverse ? WIDTH-1-i : i.
- Write side: when tag emerges, unit_set_weight=1, unit_set_weight_row=tag.row, unit_data_in = tag.zero ? all 0.0 : data_mem_data_out (combinational pass-through, no extra register).
- DRAIN: hold address at last value; count MEM_LATENCY cycles; go DONE.
- DONE: done=1, busy=0, one cycle; next IDLE, or ISSUE if start.
- Zero-filled rows still drive an address (base+i); read data discarded.
- Not-writing outputs: unit_set_weight=0, unit_set_weight_row=0, unit_data_in all 0.0; data_mem_read_addr=0 in IDLE/DONE.

## Timing
- Reset (async, immediate): state IDLE, pipeline cleared, busy=0, done=0, unit_set_weight=0, unit_set_weight_row=0, unit_data_in all 0.0, data_mem_read_addr=0. Reset mid-load aborts; no further writes, no done pulse.
- Start sampled at edge E0. Cycle k (after E0, k=1..WIDTH): address base+k-1 driven, busy=1.
- Write for issue k occurs in cycle k+MEM_LATENCY; WIDTH writes, consecutive, no gaps.
- done in cycle WIDTH+MEM_LATENCY+1; busy=1 cycles 1..WIDTH+MEM_LATENCY.
- Total latency start→done: WIDTH+MEM_LATENCY+1 cycles. Back-to-back: start during done → next load's first address in the following cycle.
- num_rows=0: all WIDTH rows written 0.0. num_rows>WIDTH: clamped to WIDTH.
- Address wrap: base=2^N-2 issues 2^N-2, 2^N-1, 0, 1, ...

## Test plan
- WIDTH=4, L=0, base=8, num_rows=4, reverse=0 -> addr 8,9,10,11 in cycles 1-4; rows 0,1,2,3 written same cycles with mem data; done cycle 5.
- WIDTH=4, L=2, reverse=1, base=0 -> writes cycles 3-6 to rows 3,2,1,0 carrying mem rows 0..3; busy cycles 1-6; done cycle 7.
- num_rows=2, WIDTH=4 -> rows 0,1 from memory, rows 2,3 all 0.0; num_rows=0 -> four 0.0 rows; num_rows=7 -> treated as 4.
- Start pulsed in cycle 2 of a load -> ignored, single done; start during done cycle -> second load begins next cycle, addresses from new base_addr.
- Reset asserted in cycle 3 of a load -> unit_set_weight falls immediately, all outputs at reset values, no done; fresh start after release behaves normally.
- base=32'hFFFF_FFFE, WIDTH=4 -> addresses FFFF_FFFE, FFFF_FFFF, 0, 1.
